moving_avg_filt: RTL and testbench
==================================

Name: moving_avg_filt

Overview:
- Boxcar (moving-average) stage directly downstream of the 5-tap median filter.
- Consumes the median tap stream and outputs the rounded mean of the last N = 2**LOG2N accepted samples.
- Uses an O(1) running-sum update: add the newest sample, subtract the sample leaving the circular window.
- Valid/ready handshake on both sides, so it can sit between the median filter and a back-pressuring consumer.

Parameters:
- W, 8, sample width in bits (input and output).
- LOG2N, 3, log2 of window length; N = 8 taps. Legal range 1..6.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- dI  in  W  input sample (median value), unsigned.
- in_valid  in  1  dI is valid this cycle.
- in_ready  out  1  block accepts dI this cycle.
- clr  in  1  synchronous flush of window, sum and fill count.
- avg  out  W  rounded window mean, unsigned.
- out_valid  out  1  avg holds an unconsumed result.
- out_ready  in  1  downstream takes avg this cycle.
- filled  out  1  window holds N real samples (state RUN).

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: ring buffer all 0, sum 0, wptr 0, fill count 0, state FILL, avg 0, out_valid 0, filled 0.
- Accept condition: acc = in_valid && in_ready.
- Ready rule: in_ready = !out_valid || out_ready. in_ready is combinational from out_ready and has no path from in_valid.
- Sum register width: W+LOG2N bits. This cannot overflow, since max sum = N*(2**W-1).
- On acc:
  - sum_n = sum + dI - buf[wptr].
  - buf[wptr] <= dI.
  - wptr <= wptr+1, wrapping modulo N.
- Rounding: avg_n = (sum_n + 2**(LOG2N-1)) >> LOG2N, round-half-up. The result always fits W bits.
- State FILL:
  - fill count counts accepts from 0 to N-1; no output is produced (out_valid stays 0).
  - The accept that brings the count to N moves the state to RUN, asserts filled, and produces the first output.
- State RUN: every acc loads avg <= avg_n and sets out_valid <= 1 on the next edge. Latency is 1 cycle from acc to out_valid.
- Output handshake:
  - out_valid && out_ready && !acc: clear out_valid.
  - out_valid && out_ready && acc: keep out_valid = 1 and load the new avg (full throughput, 1 sample per clock).
  - out_valid && !out_ready: avg and out_valid hold stable; in_ready = 0.
- clr:
  - Takes priority over acc in the same cycle; the sample presented with clr is discarded.
  - Next edge: buffer 0, sum 0, wptr 0, count 0, state FILL, out_valid 0, filled 0. avg keeps its last value.
- Async reset mid-operation: all state goes to reset values immediately, independent of clk. The first post-reset output again needs N accepts.
- dI is ignored when in_valid is 0. in_valid may drop at any time with no penalty.
- Invariant (verify): sum == sum of all buf entries at every edge.

Decomposition:
- Package moving_avg_pkg holds:
  - default W and LOG2N;
  - typedef enum logic {FILL, RUN} maf_state_t;
  - localparam function for the sum width, W+LOG2N.
- One sub-module, maf_ring: N-entry x W circular buffer with write pointer. It takes clk, rst_n, clr and the write enable, and exposes the oldest entry combinationally.
- The top module holds the FSM, accumulator, rounding and output register.

Test Plan:
- Constant 100 on every cycle, out_ready = 1 -> out_valid first rises 1 cycle after the 8th accept with avg = 100; thereafter 100 on every cycle.
- Inputs 0,1,...,7 -> first avg = (28+4)>>3 = 4. Next input 8 -> sum 36, avg = (36+4)>>3 = 5.
- All inputs 255 for 20 cycles -> sum = 2040 with no overflow, avg = 255. Then inputs 0 -> avg falls one step per accept (255*7/8 -> 223 ... 0).
- Backpressure: in RUN, hold out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0 and avg/out_valid frozen, no samples lost. Release -> the next 5 outputs match the golden model.
- Assert clr in RUN while in_valid = 1 -> out_valid = 0 and filled = 0 next cycle. 8 fresh samples of 40 -> avg = 40, with no contribution from pre-clr data.
- Drop rst_n asynchronously mid-clock in RUN -> all outputs 0 immediately. After release, feed ramp 10..17 -> first avg = (108+4)>>3 = 14.

Source files
------------

// File: rtl/moving_avg_filt_pkg.sv
// ============================================================================
// moving_avg_pkg : shared defaults, FSM state type and sum-width helper for
//                  the moving-average filter.
// Revision 1.0
// ============================================================================
`default_nettype none

package moving_avg_pkg;

  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_LOG2N = 3;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } maf_state_t;

  // Wide enough for N full-scale samples, so the running sum never wraps.
  function automatic int unsigned sum_width(input int unsigned w, input int unsigned log2n);
    return w + log2n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/moving_avg_filt_ring.sv
// ============================================================================
// maf_ring : N-entry circular sample buffer; exposes the entry about to be
//            overwritten (the oldest sample) combinationally.
// Revision 1.0
// ============================================================================
`default_nettype none

module maf_ring #(
  parameter int unsigned W     = 8,
  parameter int unsigned LOG2N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] oldest_o
);

  localparam int unsigned N = 1 << LOG2N;

  logic [W-1:0]     mem_q [N];
  logic [LOG2N-1:0] wptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      wptr_q <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      wptr_q <= '0;
    end else if (we_i) begin
      mem_q[wptr_q] <= din_i;
      wptr_q        <= wptr_q + LOG2N'(1);
    end
  end

  assign oldest_o = mem_q[wptr_q];

endmodule

`default_nettype wire

// File: rtl/moving_avg_filt.sv
// ============================================================================
// moving_avg_filt : boxcar filter producing the rounded mean of the last
//                   2**LOG2N accepted samples, valid/ready on both sides.
// Revision 1.0
// ============================================================================
`default_nettype none

module moving_avg_filt
  import moving_avg_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned LOG2N = DEF_LOG2N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] dI,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         clr,
  output logic [W-1:0] avg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         filled
);

  localparam int unsigned      N        = 1 << LOG2N;
  localparam int unsigned      SW       = sum_width(W, LOG2N);
  localparam logic [SW-1:0]    RND      = SW'(N / 2);
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  maf_state_t       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [W-1:0]     avg_q, avg_d;
  logic             out_valid_q, out_valid_d;

  logic             acc;
  logic [W-1:0]     oldest;
  logic [SW-1:0]    sum_n;
  logic [SW-1:0]    rnd_sum;
  logic [W-1:0]     avg_n;

  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;

  maf_ring #(
    .W     (W),
    .LOG2N (LOG2N)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr),
    .we_i     (acc && !clr),
    .din_i    (dI),
    .oldest_o (oldest)
  );

  // The sum always covers the buffer contents, so it is never below oldest.
  assign sum_n   = sum_q + SW'(dI) - SW'(oldest);
  assign rnd_sum = sum_n + RND;
  assign avg_n   = rnd_sum[SW-1:LOG2N];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    avg_d       = avg_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      state_d     = FILL;
      cnt_d       = '0;
      sum_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (acc) begin
        sum_d = sum_n;
        case (state_q)
          FILL: begin
            if (cnt_q == CNT_LAST) begin
              state_d     = RUN;
              avg_d       = avg_n;
              out_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + LOG2N'(1);
            end
          end
          RUN: begin
            avg_d       = avg_n;
            out_valid_d = 1'b1;
          end
          default: state_d = FILL;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      avg_q       <= avg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign avg       = avg_q;
  assign out_valid = out_valid_q;
  assign filled    = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_moving_avg_filt.sv
// ============================================================================
// tb_moving_avg_filt : directed stimulus against a window-history model of
//                      the moving-average filter.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_moving_avg_filt;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dI = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       clr = 1'b0;
  logic [7:0] avg;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       filled;

  int nchk = 0;
  int nerr = 0;

  moving_avg_filt #(.W(8), .LOG2N(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dI        (dI),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr       (clr),
    .avg       (avg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .filled    (filled)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: the accepted samples since the last flush, newest at the back.
  int   hist[$];
  logic m_valid = 1'b0;
  int   m_avg = 0;
  int   m_sum = 0;
  logic m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_valid = 1'b0;
      m_avg   = 0;
      m_sum   = 0;
    end else begin
      m_acc = in_valid && (!m_valid || out_ready);
      if (clr) begin
        hist.delete();
        m_valid = 1'b0;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_acc) begin
          hist.push_back(int'(dI));
          if (hist.size() > N) void'(hist.pop_front());
          if (hist.size() == N) begin
            m_sum = 0;
            foreach (hist[i]) m_sum += hist[i];
            m_avg   = (m_sum + N / 2) / N;
            m_valid = 1'b1;
          end
        end
      end
      m_sum = 0;
      foreach (hist[i]) m_sum += hist[i];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("filled", int'(filled), int'(hist.size() == N));
      chk("in_ready", int'(in_ready), int'(!m_valid || out_ready));
      chk("avg", int'(avg), m_avg);
      chk("sum_invariant", int'(dut.sum_q), m_sum);
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic c);
    in_valid  = v;
    dI        = d;
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("reset_avg", int'(avg), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_filled", int'(filled), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 8'd0, 1, 0);

    // Constant 100
    for (int i = 0; i < 7; i++) step(1, 8'd100, 1, 0);
    chk("const_not_yet_valid", int'(out_valid), 0);
    step(1, 8'd100, 1, 0);
    chk("const_first_valid", int'(out_valid), 1);
    chk("const_first_avg", int'(avg), 100);
    chk("const_filled", int'(filled), 1);
    for (int i = 0; i < 4; i++) step(1, 8'd100, 1, 0);
    chk("const_steady_avg", int'(avg), 100);

    // Backpressure: output frozen, nothing accepted
    for (int i = 0; i < 5; i++) begin
      step(1, 8'd200, 0, 0);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_avg_frozen", int'(avg), 100);
      chk("bp_valid_held", int'(out_valid), 1);
    end
    step(1, 8'd200, 1, 0);
    chk("bp_release_avg", int'(avg), 113);
    for (int i = 0; i < 4; i++) step(1, 8'd200, 1, 0);

    // Flush in RUN while a sample is offered
    step(1, 8'd99, 1, 1);
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_filled", int'(filled), 0);
    chk("clr_sum", int'(dut.sum_q), 0);

    // Ramp 0..7 then 8
    for (int i = 0; i < 8; i++) step(1, 8'(i), 1, 0);
    chk("ramp_first_avg", int'(avg), 4);
    step(1, 8'd8, 1, 0);
    chk("ramp_next_avg", int'(avg), 5);

    // Full scale then decay
    step(0, 8'd0, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 8'd255, 1, 0);
    chk("full_avg", int'(avg), 255);
    chk("full_sum", int'(dut.sum_q), 2040);
    step(1, 8'd0, 1, 0);
    chk("decay_first", int'(avg), 223);
    for (int i = 0; i < 7; i++) step(1, 8'd0, 1, 0);
    chk("decay_last", int'(avg), 0);

    // Idle input: pending result drains, garbage dI ignored
    step(0, 8'hAA, 1, 0);
    chk("idle_valid_drop", int'(out_valid), 0);
    step(0, 8'h55, 0, 0);
    chk("idle_filled", int'(filled), 1);

    // Flush then 40s with gaps
    step(1, 8'd7, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 8'd40, 0, 0);
      if (i == 3) step(0, 8'd250, 1, 0);
    end
    chk("fresh40_avg", int'(avg), 40);
    chk("fresh40_valid", int'(out_valid), 1);
    step(0, 8'd0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 8'd90, 1, 0);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_avg", int'(avg), 0);
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_filled", int'(filled), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step(1, 8'(10 + i), 1, 0);
    chk("post_reset_not_valid", int'(out_valid), 0);
    step(1, 8'd17, 1, 0);
    chk("post_reset_avg", int'(avg), 14);
    step(0, 8'd0, 1, 0);
    step(0, 8'd0, 1, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
